// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the
// oversampling divider helper used by both receiver and transmitter.
package uart_pkg;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int baud_div(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: power-of-two FIFO with an extra pointer bit for full/empty
// detection and a registered head byte.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       valid,
  output logic       dropped
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [7:0]  head_q, head_d;
  logic        empty, full, do_pop, do_push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid = !empty;
  assign dout  = head_q;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    dropped  = push && full && !do_pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // Reading through mem_d forwards a byte written into the slot that becomes the head.
    head_d = mem_d[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 16x oversampled, 3-sample majority vote, optional
// parity, sticky error flags, and a small FIFO with a valid/ready read port.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  input  logic       err_clr
);
  localparam int DIV = baud_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    smp_q, smp_d;
  logic          s7_q, s7_d, s8_q, s8_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          brk_q, brk_d;
  logic          frame_err_q, frame_err_d;
  logic          parity_err_q, parity_err_d;
  logic          overrun_q, overrun_d;
  rx_state_e     state_q, state_d;

  logic rxs, tick, sample, vote, push, dropped, frame_set, parity_set;

  assign rxs        = sync_q[1];
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

  always_comb begin
    sync_d     = {sync_q[0], rx};
    tick       = (div_q == DW'(DIV - 1));
    sample     = tick && (smp_q == 4'd9);
    vote       = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);
    div_d      = tick ? '0 : div_q + 1'b1;
    smp_d      = tick ? smp_q + 1'b1 : smp_q;
    s7_d       = (tick && smp_q == 4'd7) ? rxs : s7_q;
    s8_d       = (tick && smp_q == 4'd8) ? rxs : s8_q;
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    brk_d      = brk_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Holding the counters at zero aligns the sample phase to the start edge.
        div_d     = '0;
        smp_d     = '0;
        bit_idx_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (sample) state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7)
            state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          parity_set = (vote != ((^shift_q) ^ (PARITY_MODE == PAR_ODD)));
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (brk_q) begin
          if (rxs) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (sample) begin
          if (vote) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            brk_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_err_d  = frame_set  | (frame_err_q  & ~err_clr);
    parity_err_d = parity_set | (parity_err_q & ~err_clr);
    overrun_d    = dropped    | (overrun_q    & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      div_q        <= '0;
      smp_q        <= '0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      brk_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      sync_q       <= sync_d;
      div_q        <= div_d;
      smp_q        <= smp_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      brk_q        <= brk_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .din    (shift_q),
    .pop    (rd_ready),
    .dout   (rd_data),
    .valid  (rd_valid),
    .dropped(dropped)
  );

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: two receivers (8N1 and 8E1) at 16 clocks per bit,
// directed scenarios plus random traffic checked against a byte-queue model.
module tb_uart_byte_rx;
  localparam int DEPTH  = 4;
  localparam int BITLEN = 16;
  // Stop-bit decision: 2 sync + 1 detect cycles, then sample 9 of the last bit.
  localparam int DECIDE_OFS = 3 + 9;
  localparam int STOP_CYC_8N1 = DECIDE_OFS + 9 * BITLEN;

  logic clk = 1'b0;
  logic rst_n, rx0, rx1, rdy0, rdy1, err_clr;
  logic [7:0] data0, data1;
  logic valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1;

  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit efe[2], epe[2], eov[2];
  int n_cmp, n_fail;

  always #5 clk = ~clk;

  uart_byte_rx #(.SYS_CLK_FREQ(16000000), .BAUD_RATE(1000000),
                 .PARITY_MODE(0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rd_data(data0), .rd_valid(valid0),
    .rd_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
    .err_clr(err_clr));

  uart_byte_rx #(.SYS_CLK_FREQ(16000000), .BAUD_RATE(1000000),
                 .PARITY_MODE(1), .FIFO_DEPTH(DEPTH)) dut_par (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rd_data(data1), .rd_valid(valid1),
    .rd_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
    .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      efe[i] = 1'b0;
      epe[i] = 1'b0;
      eov[i] = 1'b0;
    end
  endtask

  // Called 2 time units after a negedge; reads accepted this cycle leave the model.
  task automatic check_output();
    chk("valid0", valid0, mq0.size() != 0);
    chk("valid1", valid1, mq1.size() != 0);
    if (rdy0 && mq0.size() != 0) begin
      chk("data0", data0, mq0[0]);
      mq0.delete(0);
    end
    if (rdy1 && mq1.size() != 0) begin
      chk("data1", data1, mq1[0]);
      mq1.delete(0);
    end
    chk("frame_err0", fe0, efe[0]);
    chk("parity_err0", pe0, epe[0]);
    chk("overrun0", ov0, eov[0]);
    chk("frame_err1", fe1, efe[1]);
    chk("parity_err1", pe1, epe[1]);
    chk("overrun1", ov1, eov[1]);
  endtask

  task automatic idle(input int n, input logic rxv, input int clr_at);
    for (int i = 0; i < n; i++) begin
      rx0 = rxv;
      rx1 = 1'b1;
      err_clr = (i == clr_at);
      #2;
      check_output();
      if (err_clr) begin
        for (int k = 0; k < 2; k++) begin
          efe[k] = 1'b0;
          epe[k] = 1'b0;
          eov[k] = 1'b0;
        end
      end
      @(negedge clk);
    end
    err_clr = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    clear_model();
    for (int i = 0; i < n; i++) begin
      #2;
      check_output();
      chk("rst_data0", data0, 8'h00);
      chk("rst_data1", data1, 8'h00);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  // which=0 drives the 8N1 receiver, which=1 the even-parity receiver.
  task automatic send_frame(input int which, input logic [7:0] data, input bit bad_par,
                            input bit stop_low, input int ready_cyc, input bit rnd_ready,
                            input int abort_at);
    logic [10:0] bits;
    int nb, total, ev_cyc, idx;
    logic par;
    par = ^data;
    if (bad_par) par = ~par;
    nb = (which == 1) ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (which == 1) bits[9] = par;
    bits[nb-1] = ~stop_low;
    total  = (nb - 1) * BITLEN + (stop_low ? 2 * BITLEN : BITLEN);
    ev_cyc = DECIDE_OFS + (nb - 1) * BITLEN;
    for (int c = 0; c < total; c++) begin
      if (c == abort_at) return;
      idx = c / BITLEN;
      if (idx > nb - 1) idx = nb - 1;
      rx0 = (which == 0) ? bits[idx] : 1'b1;
      rx1 = (which == 1) ? bits[idx] : 1'b1;
      if (rnd_ready) begin
        rdy0 = 1'($urandom_range(0, 1));
        rdy1 = 1'($urandom_range(0, 1));
      end
      if (c == ready_cyc) begin
        if (which == 0) rdy0 = 1'b1;
        else rdy1 = 1'b1;
      end
      #2;
      check_output();
      if (which == 1 && bad_par && c == ev_cyc - BITLEN) epe[1] = 1'b1;
      if (c == ev_cyc) begin
        if (stop_low) efe[which] = 1'b1;
        else if (which == 0) begin
          if (mq0.size() < DEPTH) mq0.push_back(data);
          else eov[0] = 1'b1;
        end else begin
          if (mq1.size() < DEPTH) mq1.push_back(data);
          else eov[1] = 1'b1;
        end
      end
      @(negedge clk);
    end
    rx0 = 1'b1;
    rx1 = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    int w;
    bit bp, sl;
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    apply_reset(3);
    idle(5, 1'b1, -1);

    $display("[TB] clean byte 0xA5");
    send_frame(0, 8'hA5, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(4, 1'b1, -1);
    chk("clean_data", data0, 8'hA5);
    rdy0 = 1'b1;
    idle(4, 1'b1, -1);
    rdy0 = 1'b0;

    $display("[TB] glitch rejection");
    idle(4, 1'b0, -1);
    idle(40, 1'b1, -1);

    $display("[TB] framing error and recovery");
    send_frame(0, 8'h3C, 1'b0, 1'b1, -1, 1'b0, -1);
    idle(10, 1'b1, -1);
    send_frame(0, 8'h55, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(3, 1'b1, -1);
    chk("after_break_data", data0, 8'h55);
    rdy0 = 1'b1;
    idle(3, 1'b1, -1);
    rdy0 = 1'b0;
    idle(4, 1'b1, 1);

    $display("[TB] even parity");
    send_frame(1, 8'h07, 1'b1, 1'b0, -1, 1'b0, -1);
    idle(3, 1'b1, -1);
    chk("par_bad_data", data1, 8'h07);
    idle(4, 1'b1, 1);
    send_frame(1, 8'h07, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(3, 1'b1, -1);
    rdy1 = 1'b1;
    idle(4, 1'b1, -1);
    rdy1 = 1'b0;

    $display("[TB] overrun");
    for (int b = 1; b <= 5; b++) send_frame(0, 8'(b), 1'b0, 1'b0, -1, 1'b0, -1);
    idle(3, 1'b1, -1);
    rdy0 = 1'b1;
    idle(8, 1'b1, -1);
    rdy0 = 1'b0;
    idle(4, 1'b1, 1);

    $display("[TB] full FIFO with simultaneous push and pop");
    for (int b = 1; b <= 4; b++) send_frame(0, 8'(b), 1'b0, 1'b0, -1, 1'b0, -1);
    send_frame(0, 8'h05, 1'b0, 1'b0, STOP_CYC_8N1, 1'b0, -1);
    idle(10, 1'b1, -1);
    rdy0 = 1'b0;

    $display("[TB] random traffic");
    for (int n = 0; n < 16; n++) begin
      w  = int'($urandom_range(0, 1));
      rb = 8'($urandom);
      bp = (w == 1) && ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 5) == 0);
      send_frame(w, rb, bp, sl, -1, 1'b1, -1);
      idle(int'($urandom_range(sl ? 5 : 0, 12)), 1'b1,
           ($urandom_range(0, 3) == 0) ? 0 : -1);
    end
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    idle(12, 1'b1, 0);
    rdy0 = 1'b0;
    rdy1 = 1'b0;

    $display("[TB] reset mid-frame");
    send_frame(0, 8'h11, 1'b0, 1'b0, -1, 1'b0, -1);
    send_frame(0, 8'h22, 1'b0, 1'b0, -1, 1'b0, -1);
    send_frame(0, 8'h33, 1'b0, 1'b1, -1, 1'b0, -1);
    idle(10, 1'b1, -1);
    send_frame(0, 8'h99, 1'b0, 1'b0, -1, 1'b0, 70);
    apply_reset(3);
    idle(40, 1'b1, -1);
    send_frame(0, 8'h5A, 1'b0, 1'b0, -1, 1'b0, -1);
    idle(3, 1'b1, -1);
    chk("post_reset_data", data0, 8'h5A);
    rdy0 = 1'b1;
    idle(4, 1'b1, -1);
    rdy0 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

UART receiver that deserializes the serial line driven toward `riscv_top` (the host-to-CPU direction of the `Rx` pin) into bytes. It buffers those bytes for the host-communication logic. It uses 16x oversampling with a majority vote, supports optional parity, and reports framing, parity and overrun errors. Bytes are delivered through a small FIFO with a valid/ready read port.

## Interface
- `SYS_CLK_FREQ`, 100000000, clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `PARITY_MODE`, 0, parity setting: 0 none, 1 even, 2 odd.
- `FIFO_DEPTH`, 4, number of receive buffer entries; must be a power of two, at least 2.

- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  asynchronous serial input; idle level is high.
- `rd_data`  out  8  head byte of the FIFO.
- `rd_valid`  out  1  FIFO is non-empty.
- `rd_ready`  in  1  consumer accepts the head byte.
- `frame_err`  out  1  sticky flag: a stop bit was sampled low.
- `parity_err`  out  1  sticky flag: parity mismatch.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `err_clr`  in  1  single-cycle pulse that clears all three sticky flags.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, which resets to 1. All logic below uses the synchronized value `rxs`.
- **Tick generator:**
  - DIV = SYS_CLK_FREQ / (BAUD_RATE*16), using integer truncation; DIV must be at least 1.
  - The counter runs from 0 to DIV-1 and asserts `tick` for one cycle when it wraps.
  - The counter is cleared when the FSM leaves IDLE, so the sample phase is aligned to the start edge.
- **Sample counter:** 4 bits, advances on each `tick`. Within every bit period the block keeps the samples at counts 7, 8 and 9. The bit value is the majority of those three and is taken at count 9.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** when `rxs`=0, go to START.
  - **START:** at count 9, a majority of 1 is treated as a glitch and the FSM returns to IDLE. A majority of 0 goes to DATA.
  - **DATA:** shifts 8 bits in, LSB first. The bit index is 3 bits. After bit 7, go to PARITY if PARITY_MODE≠0, otherwise STOP.
  - **PARITY:** sample the parity bit. Expected value for even parity is the XOR of the data bits; for odd parity it is the inverse. A mismatch sets `parity_err`, and the byte is still pushed.
  - **STOP:** at count 9, a majority of 1 pushes the byte and returns to IDLE. A majority of 0 sets `frame_err`, discards the byte, and waits for `rxs`=1 before returning to IDLE. This is break handling.
- **Back-to-back frames:** the FSM returns to IDLE at mid-stop-bit, so a start edge in the second half of the stop bit is captured.
- **FIFO:**
  - Push happens in the cycle the STOP decision is made. A read occurs when `rd_valid`&&`rd_ready`.
  - Push while full with no pop: the byte is dropped, `overrun` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur and `overrun` is not set.
  - Push and pop in the same cycle while empty: only the push takes effect, because `rd_valid` was 0.
- **Sticky flags:** set events take priority over `err_clr` in the same cycle.

## Timing
- **Reset values:** `rd_valid`=0, `rd_data`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. The FSM is in IDLE, all counters are 0, the FIFO is empty, and the synchronizer flops are 1.
- **Reset mid-frame:** the partial byte is discarded. After `rst_n` rises, the block needs a new falling edge to start a frame.
- **Start-edge latency:** 2 cycles of synchronizer delay from an `rx` edge to `rxs`.
- **Byte latency:** `rd_valid` rises 1 cycle after the push, i.e. about 9.56 bit periods after the start edge with no parity.
- **Read port:** `rd_data` is the registered head entry and is stable while `rd_valid`=1 and `rd_ready`=0. After a read, the next entry appears on the following cycle.
- **Error flags:** each flag asserts 1 cycle after its detection event.

## Structure
- Shared package `uart_pkg`:
  - Parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
  - FSM state enum.
  - A `baud_div` function computing DIV from SYS_CLK_FREQ and BAUD_RATE.
  - This package is reused by the companion transmitter.
- Sub-module `uart_rx_fifo`: synchronous FIFO with parameter DEPTH, push/pop, full/empty, and a registered head output. Its pointers are $clog2(DEPTH)+1 bits wide, with the MSB used for wrap detection.

## Test plan
- **Clean byte:** SYS_CLK_FREQ=16000000, BAUD_RATE=1000000 (DIV=1, 16 cycles per bit). Send 0xA5 8N1 → `rd_valid` rises, `rd_data`=0xA5, all error flags stay 0.
- **Glitch rejection:** drive `rx` low for 4 cycles, then high → no byte is produced and the FSM returns to IDLE.
- **Framing error:** send 0x3C with the stop bit held low for 32 cycles → `frame_err`=1 and FIFO stays empty. Then send 0x55 → `rd_data`=0x55. Pulse `err_clr` → `frame_err`=0.
- **Parity, PARITY_MODE=1 (even):** send 0x07 with parity bit 0 → byte is pushed and `parity_err`=1. Send 0x07 with parity bit 1 → `parity_err` is not newly set.
- **Overrun:** FIFO_DEPTH=4, `rd_ready`=0, send 0x01..0x05 back-to-back → `overrun`=1, reads return 0x01–0x04, 0x05 is lost.
- **Full-FIFO simultaneous push/pop:** with the FIFO full, hold `rd_ready`=1 through the 5th stop-bit decision → no overrun, and reads return 0x01–0x05 in order. Additionally, asserting `rst_n`=0 mid-byte leaves FIFO empty and all flags at 0.
